// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and defaults for the SPI master arbiter.
//   arb_state_e : FSM encoding (IDLE=0, START=1, WAIT=2, GAP=3)
//   DEF_*       : default parameter values for spi_arbiter
//   cnt_w()     : counter width for a count range of n (never below 1 bit)
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TIMEOUT    = 1024;
    localparam int DEF_GAP_CYCLES = 4;
    localparam int DEF_CNT_W      = $clog2(DEF_TIMEOUT);

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// spi_rr_pick: two-input round-robin picker (purely combinational).
//   req0_i, req1_i : pending requests
//   last_grant_i   : requester granted most recently
//   valid_o        : at least one request pending
//   grant_o        : winning requester index
module spi_rr_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic grant_o
);
    assign valid_o = req0_i | req1_i;
    // On a tie the requester that did not win last time goes next;
    // otherwise the lone requester wins (req1 alone -> 1, req0 alone -> 0).
    assign grant_o = (req0_i & req1_i) ? ~last_grant_i : req1_i;
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi_master between two requesters.
//   clk, reset               : clock, synchronous active-high reset
//   req0/1, tx_data0/1       : level requests and their transmit bytes
//   done0/1, err0/1          : one-cycle completion / timeout pulses
//   rx_data0/1               : received byte, held until the next done
//   busy                     : arbiter not idle
//   master_start             : one-cycle trigger to spi_master
//   master_tx_data           : latched byte of the current winner
//   master_rx_data/_rx_done  : master receive data and completion pulse
// All outputs come straight from registers.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] tx_data0,
    input  logic [DATA_WIDTH-1:0] tx_data1,
    output logic                  done0,
    output logic                  done1,
    output logic                  err0,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] rx_data0,
    output logic [DATA_WIDTH-1:0] rx_data1,
    output logic                  busy,
    output logic                  master_start,
    output logic [DATA_WIDTH-1:0] master_tx_data,
    input  logic [DATA_WIDTH-1:0] master_rx_data,
    input  logic                  master_rx_done
);
    localparam int CW = cnt_w(TIMEOUT);
    localparam int GW = cnt_w(GAP_CYCLES);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    arb_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GW-1:0]         gcnt_q, gcnt_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rx0_q, rx0_d, rx1_q, rx1_d;
    logic                  done0_q, done0_d, done1_q, done1_d;
    logic                  err0_q, err0_d, err1_q, err1_d;
    logic                  start_q, start_d, busy_q, busy_d;

    logic pick_valid, pick_grant;

    spi_rr_pick u_pick (
        .req0_i      (req0),
        .req1_i      (req1),
        .last_grant_i(last_q),
        .valid_o     (pick_valid),
        .grant_o     (pick_grant)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        tx_d    = tx_q;
        rx0_d   = rx0_q;
        rx1_d   = rx1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_grant;
                    last_d  = pick_grant;
                    tx_d    = pick_grant ? tx_data1 : tx_data0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A response landing on the final timeout cycle counts as
                // success: the done branch is checked first.
                if (master_rx_done || cnt_q == TO_LAST) begin
                    if (owner_q) begin
                        done1_d = 1'b1;
                        err1_d  = ~master_rx_done;
                        rx1_d   = master_rx_done ? master_rx_data : '0;
                    end else begin
                        done0_d = 1'b1;
                        err0_d  = ~master_rx_done;
                        rx0_d   = master_rx_done ? master_rx_data : '0;
                    end
                    gcnt_d  = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt_q == GAP_LAST) state_d = ST_IDLE;
                else                    gcnt_d  = gcnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered from next state so both are valid the cycle after grant.
        start_d = (state_d == ST_START);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            tx_q    <= '0;
            rx0_q   <= '0;
            rx1_q   <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            tx_q    <= tx_d;
            rx0_q   <= rx0_d;
            rx1_q   <= rx1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign done0          = done0_q;
    assign done1          = done1_q;
    assign err0           = err0_q;
    assign err1           = err1_q;
    assign rx_data0       = rx0_q;
    assign rx_data1       = rx1_q;
    assign busy           = busy_q;
    assign master_start   = start_q;
    assign master_tx_data = tx_q;
endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;
    localparam int TO  = 32;
    localparam int GAP = 4;

    logic clk = 1'b0, reset = 1'b1;
    logic req0 = 0, req1 = 0, master_rx_done = 0;
    logic [7:0] tx_data0 = 0, tx_data1 = 0, master_rx_data = 0;
    logic done0, done1, err0, err1, busy, master_start;
    logic [7:0] rx_data0, rx_data1, master_tx_data;

    // Second instance with TIMEOUT=4 for the done/timeout coincidence.
    logic b_req0 = 0, b_req1 = 0, b_mrxd = 0;
    logic [7:0] b_tx0 = 0, b_tx1 = 0, b_mrx = 0;
    logic b_done0, b_done1, b_err0, b_err1, b_busy, b_start;
    logic [7:0] b_rx0, b_rx1, b_mtx;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    spi_arbiter #(.DATA_WIDTH(8), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .tx_data0(tx_data0), .tx_data1(tx_data1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rx_data0(rx_data0), .rx_data1(rx_data1), .busy(busy),
        .master_start(master_start), .master_tx_data(master_tx_data),
        .master_rx_data(master_rx_data), .master_rx_done(master_rx_done)
    );

    spi_arbiter #(.DATA_WIDTH(8), .TIMEOUT(4), .GAP_CYCLES(GAP)) dut4 (
        .clk(clk), .reset(reset), .req0(b_req0), .req1(b_req1),
        .tx_data0(b_tx0), .tx_data1(b_tx1),
        .done0(b_done0), .done1(b_done1), .err0(b_err0), .err1(b_err1),
        .rx_data0(b_rx0), .rx_data1(b_rx1), .busy(b_busy),
        .master_start(b_start), .master_tx_data(b_mtx),
        .master_rx_data(b_mrx), .master_rx_done(b_mrxd)
    );

    typedef struct {
        logic       r0, r1;
        logic [7:0] t0, t1;
        logic [7:0] rx;      // byte the master model returns
        int         dly;     // response delay after start, 0 = never
        logic       drop;    // drop requests right after start
        logic       exp_own;
        logic [7:0] exp_tx;
        logic       exp_err;
        logic [7:0] exp_rx;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_start(output logic got, output int n);
        got = 0;
        n = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            n = i;
            if (master_start) got = 1;
        end
    endtask

    task automatic wait_idle(input string nm);
        logic ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        chk(nm, ok, 1);
    endtask

    // Run one transfer from IDLE and check grant, data, pulses and latency.
    task automatic run_vec(input vec_t v, input string nm);
        logic got, fin;
        int n, lat, exp_lat;
        @(negedge clk);
        req0 = v.r0; req1 = v.r1; tx_data0 = v.t0; tx_data1 = v.t1;
        master_rx_data = v.rx;
        wait_start(got, n);
        chk({nm, " start"}, got, 1);
        if (!got) begin req0 = 0; req1 = 0; return; end
        chk({nm, " tx"}, master_tx_data, v.exp_tx);
        chk({nm, " busy"}, busy, 1);
        if (v.drop) begin req0 = 0; req1 = 0; end
        fin = 0;
        lat = 0;
        for (int k = 1; k <= TO + 10 && !fin; k++) begin
            @(negedge clk);
            master_rx_done = 0;
            lat = k;
            if (done0 || done1) fin = 1;
            else if (k == v.dly) master_rx_done = 1;
        end
        master_rx_done = 0;
        exp_lat = (v.dly != 0 && v.dly <= TO) ? v.dly + 1 : TO + 1;
        chk({nm, " done"}, fin, 1);
        chk({nm, " latency"}, lat, exp_lat);
        chk({nm, " owner"}, {done1, done0}, v.exp_own ? 2'b10 : 2'b01);
        chk({nm, " err"}, {err1, err0}, v.exp_err ? (v.exp_own ? 2'b10 : 2'b01) : 2'b00);
        chk({nm, " rx"}, v.exp_own ? rx_data1 : rx_data0, v.exp_rx);
        req0 = 0; req1 = 0;
        wait_idle({nm, " idle"});
    endtask

    vec_t tbl[6];

    initial begin
        automatic logic got;
        automatic int n;
        automatic logic [1:0] exp_g;
        automatic logic fin;

        tbl[0] = '{1,0,8'h2A,8'h00,8'hAD,20,0, 0,8'h2A,0,8'hAD};
        tbl[1] = '{1,1,8'h11,8'h22,8'h33, 3,0, 1,8'h22,0,8'h33};
        tbl[2] = '{1,1,8'h44,8'h55,8'h66, 5,0, 0,8'h44,0,8'h66};
        tbl[3] = '{0,1,8'h00,8'h77,8'h99, 0,0, 1,8'h77,1,8'h00};
        tbl[4] = '{1,1,8'h0A,8'h0B,8'hC3,TO,0, 0,8'h0A,0,8'hC3};
        tbl[5] = '{0,1,8'h00,8'h5A,8'hA5, 7,1, 1,8'h5A,0,8'hA5};

        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("reset outputs", {busy, master_start, done0, done1, err0, err1}, 6'b0);
        chk("reset data", {rx_data0, rx_data1, master_tx_data}, 24'h0);

        // Master response while idle is ignored.
        master_rx_data = 8'hEE;
        master_rx_done = 1;
        @(negedge clk);
        master_rx_done = 0;
        @(negedge clk);
        chk("idle rx_done", {done0, done1, busy, rx_data0}, 11'h0);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Both held after reset: grants alternate 0,1,0,1 with GAP+1 spacing.
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        tx_data0 = 8'hA0; tx_data1 = 8'hB1; master_rx_data = 8'h5C;
        req0 = 1; req1 = 1;
        for (int g = 0; g < 4; g++) begin
            wait_start(got, n);
            chk("alt start", got, 1);
            if (g > 0) chk("alt spacing", n, GAP + 1);
            exp_g = g[0] ? 2'b10 : 2'b01;
            chk("alt grant", master_tx_data, g[0] ? 8'hB1 : 8'hA0);
            fin = 0;
            for (int k = 1; k <= TO + 5 && !fin; k++) begin
                @(negedge clk);
                master_rx_done = 0;
                if (done0 || done1) fin = 1;
                else if (k == 2) master_rx_done = 1;
            end
            master_rx_done = 0;
            chk("alt done", {done1, done0}, exp_g);
        end
        req0 = 0; req1 = 0;
        wait_idle("alt idle");

        // Reset five cycles into WAIT abandons the transfer silently.
        @(negedge clk);
        req0 = 1; tx_data0 = 8'h3F;
        wait_start(got, n);
        chk("rst start", got, 1);
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk("rst pre", {done0, err0}, 2'b00);
        reset = 1; req0 = 0;
        @(negedge clk);
        chk("rst abandon", {busy, master_start, done0, err0}, 4'b0);
        reset = 0;
        run_vec('{1,0,8'h6B,8'h00,8'h96,4,0, 0,8'h6B,0,8'h96}, "post-rst");

        // TIMEOUT=4: response on the last WAIT cycle wins over the timeout.
        @(negedge clk);
        b_req0 = 1; b_tx0 = 8'hC4; b_mrx = 8'h3C;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (b_start) got = 1;
        end
        chk("t4 start", got, 1);
        b_req0 = 0;
        fin = 0;
        for (int k = 1; k <= 10 && !fin; k++) begin
            @(negedge clk);
            b_mrxd = 0;
            if (b_done0) begin
                fin = 1;
                chk("t4 latency", k, 5);
            end else if (k == 4) b_mrxd = 1;
        end
        b_mrxd = 0;
        chk("t4 done", fin, 1);
        chk("t4 err", b_err0, 0);
        chk("t4 rx", b_rx0, 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
